// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Control unit for a classic multicycle MIPS-style datapath. A registered
//   state machine walks each instruction through fetch, decode and its
//   execution states, and drives the datapath strobes and mux selects from
//   the registered state and wait counter only.
//
//   Memory states (FETCH, MEM_READ, MEM_WRITE) are stretched by MEM_WAIT
//   extra cycles using a 4-bit wait counter that clears on every state change.
//
// Parameters
//   MEM_WAIT   extra wait cycles per memory access state (0..15)
//   OPC_W      opcode width; only the low 6 bits decode, upper bits must be 0
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   opCode       opcode field from the instruction register
//   PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//   ALUSrcA, RegWrite, RegDst            1-bit datapath control strobes
//   PCSource, ALUOp, ALUSrcB             2-bit mux / ALU selects
//   illegal_op   sticky flag, set when DECODE sees an undecoded opcode
//   state        current state code (debug)
// ---------------------------------------------------------------------------
module multicycle_control #(
   parameter int MEM_WAIT = 0,
   parameter int OPC_W    = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [OPC_W-1:0] opCode,
   output logic             PCWriteCond,
   output logic             PCWrite,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             MemtoReg,
   output logic             IRWrite,
   output logic             ALUSrcA,
   output logic             RegWrite,
   output logic             RegDst,
   output logic [1:0]       PCSource,
   output logic [1:0]       ALUOp,
   output logic [1:0]       ALUSrcB,
   output logic             illegal_op,
   output logic [3:0]       state
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EX   = 4'd10,
      S_ADDI_WB   = 4'd11
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_wait;
   logic        r_illegal;
   logic        w_set_illegal;
   logic        w_opc_hi_zero;
   logic [5:0]  w_op;
   logic        w_mem_done;

   logic        w_pc_write_cond;
   logic        w_pc_write;
   logic        w_iord;
   logic        w_mem_read;
   logic        w_mem_write;
   logic        w_mem_to_reg;
   logic        w_ir_write;
   logic        w_alu_src_a;
   logic        w_reg_write;
   logic        w_reg_dst;
   logic [1:0]  w_pc_source;
   logic [1:0]  w_alu_op;
   logic [1:0]  w_alu_src_b;

   // An opcode with any bit set above bit 5 never decodes.
   assign w_opc_hi_zero = ((opCode >> 6) == '0);
   assign w_op          = opCode[5:0];

   // In non-memory states the counter is always 0, so this is also the
   // "final cycle" indicator for FETCH.
   assign w_mem_done = (r_wait == WAIT_LAST);

   // State register, wait counter and sticky illegal flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_wait    <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         r_wait  <= (w_next != r_state) ? 4'd0 : r_wait + 4'd1;
         if (w_set_illegal) begin
            r_illegal <= 1'b1;
         end
      end
   end

   // Next-state logic: the only place opCode is consulted.
   always_comb begin
      w_next        = r_state;
      w_set_illegal = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (w_mem_done) w_next = S_DECODE;
         end
         S_DECODE: begin
            w_next = S_FETCH;
            if (!w_opc_hi_zero) begin
               w_set_illegal = 1'b1;
            end else begin
               case (w_op)
                  OP_RTYPE:     w_next = S_EXECUTE;
                  OP_LW, OP_SW: w_next = S_MEM_ADDR;
                  OP_BEQ:       w_next = S_BRANCH;
                  OP_J:         w_next = S_JUMP;
                  OP_ADDI:      w_next = S_ADDI_EX;
                  default:      w_set_illegal = 1'b1;
               endcase
            end
         end
         // Only lw and sw reach MEM_ADDR, so anything but sw is a load.
         S_MEM_ADDR:  w_next = (w_op == OP_SW && w_opc_hi_zero) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ: begin
            if (w_mem_done) w_next = S_MEM_WB;
         end
         S_MEM_WRITE: begin
            if (w_mem_done) w_next = S_FETCH;
         end
         S_EXECUTE:   w_next = S_R_WB;
         S_ADDI_EX:   w_next = S_ADDI_WB;
         S_MEM_WB,
         S_R_WB,
         S_BRANCH,
         S_JUMP,
         S_ADDI_WB:   w_next = S_FETCH;
         default:     w_next = S_FETCH;
      endcase
   end

   // Output decode from registered state and counter only.
   always_comb begin
      w_pc_write_cond = 1'b0;
      w_pc_write      = 1'b0;
      w_iord          = 1'b0;
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_mem_to_reg    = 1'b0;
      w_ir_write      = 1'b0;
      w_alu_src_a     = 1'b0;
      w_reg_write     = 1'b0;
      w_reg_dst       = 1'b0;
      w_pc_source     = 2'b00;
      w_alu_op        = 2'b00;
      w_alu_src_b     = 2'b00;
      case (r_state)
         S_FETCH: begin
            w_mem_read  = 1'b1;
            w_alu_src_b = 2'b01;
            // One IR load and one PC increment, on the last fetch cycle.
            w_ir_write  = w_mem_done;
            w_pc_write  = w_mem_done;
         end
         S_DECODE: begin
            w_alu_src_b = 2'b11;
         end
         S_MEM_ADDR, S_ADDI_EX: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'b10;
         end
         S_MEM_READ: begin
            w_mem_read = 1'b1;
            w_iord     = 1'b1;
         end
         S_MEM_WRITE: begin
            w_mem_write = 1'b1;
            w_iord      = 1'b1;
         end
         S_MEM_WB: begin
            w_reg_write  = 1'b1;
            w_mem_to_reg = 1'b1;
         end
         S_EXECUTE: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = 2'b10;
         end
         S_R_WB: begin
            w_reg_write = 1'b1;
            w_reg_dst   = 1'b1;
         end
         S_ADDI_WB: begin
            w_reg_write = 1'b1;
         end
         S_BRANCH: begin
            w_alu_src_a     = 1'b1;
            w_alu_op        = 2'b01;
            w_pc_write_cond = 1'b1;
            w_pc_source     = 2'b01;
         end
         S_JUMP: begin
            w_pc_write  = 1'b1;
            w_pc_source = 2'b10;
         end
         default: ;
      endcase
   end

   // Reset forces the machine into FETCH, whose final cycle would otherwise
   // strobe IRWrite/PCWrite when MEM_WAIT is 0; masking every write strobe
   // with reset keeps all architectural state untouched while it is held.
   assign PCWriteCond = w_pc_write_cond & ~reset;
   assign PCWrite     = w_pc_write      & ~reset;
   assign MemWrite    = w_mem_write     & ~reset;
   assign IRWrite     = w_ir_write      & ~reset;
   assign RegWrite    = w_reg_write     & ~reset;

   assign IorD        = w_iord;
   assign MemRead     = w_mem_read;
   assign MemtoReg    = w_mem_to_reg;
   assign ALUSrcA     = w_alu_src_a;
   assign RegDst      = w_reg_dst;
   assign PCSource    = w_pc_source;
   assign ALUOp       = w_alu_op;
   assign ALUSrcB     = w_alu_src_b;
   assign illegal_op  = r_illegal;
   assign state       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Four instances of multicycle_control (MEM_WAIT = 0, 1, 2, 15), each with
//   its own reset and opcode driver. Each driver expands an instruction into
//   its list of phases and durations and publishes the expected output word
//   for every cycle; a single compare process checks all instances on the
//   falling edge. A few hand-written literal expectations are attached to
//   specific cycles of directed instructions.
//
//   Output word layout:
//   [20:17] state, [16] PCWriteCond, [15] PCWrite, [14] IorD, [13] MemRead,
//   [12] MemWrite, [11] MemtoReg, [10] IRWrite, [9] ALUSrcA, [8] RegWrite,
//   [7] RegDst, [6:5] PCSource, [4:3] ALUOp, [2:1] ALUSrcB, [0] illegal_op
// ---------------------------------------------------------------------------
module tb_multicycle_control;

   localparam int NI = 4;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   localparam int B_PWC = 16, B_PW = 15, B_IORD = 14, B_MR = 13, B_MW = 12;
   localparam int B_M2R = 11, B_IRW = 10, B_SRCA = 9, B_RW = 8, B_RD = 7;

   localparam logic [16:0] M_PWC = 17'd1 << B_PWC;
   localparam logic [16:0] M_PW  = 17'd1 << B_PW;
   localparam logic [16:0] M_MW  = 17'd1 << B_MW;
   localparam logic [16:0] M_M2R = 17'd1 << B_M2R;
   localparam logic [16:0] M_IRW = 17'd1 << B_IRW;
   localparam logic [16:0] M_RW  = 17'd1 << B_RW;
   localparam logic [16:0] M_RD  = 17'd1 << B_RD;
   localparam logic [16:0] M_PCS = 17'h00060;
   localparam logic [16:0] M_ILL = 17'h00001;

   typedef struct packed {
      logic [20:0] m;
      logic [20:0] v;
   } pin_t;

   logic          clk;
   logic [20:0]   obs_a   [NI];
   logic [20:0]   exp_a   [NI];
   logic [20:0]   pin_m_a [NI];
   logic [20:0]   pin_v_a [NI];
   logic [NI-1:0] chk_a;
   logic [NI-1:0] pin_en_a;
   logic [NI-1:0] done_a;
   logic          fin_chk;
   int            n_cmp;
   int            n_bad;

   // Expected output word for one cycle of a given phase (state code).
   function automatic logic [20:0] vec(input int ph, input bit last,
                                       input bit rs, input bit ill);
      logic [20:0] v;
      v        = '0;
      v[20:17] = 4'(ph);
      v[0]     = ill;
      case (ph)
         0: begin
            v[B_MR] = 1'b1; v[2:1] = 2'b01;
            if (last && !rs) begin v[B_IRW] = 1'b1; v[B_PW] = 1'b1; end
         end
         1:     v[2:1] = 2'b11;
         2, 10: begin v[B_SRCA] = 1'b1; v[2:1] = 2'b10; end
         3:     begin v[B_MR] = 1'b1; v[B_IORD] = 1'b1; end
         4:     begin v[B_RW] = 1'b1; v[B_M2R] = 1'b1; end
         5:     begin v[B_MW] = 1'b1; v[B_IORD] = 1'b1; end
         6:     begin v[B_SRCA] = 1'b1; v[4:3] = 2'b10; end
         7:     begin v[B_RW] = 1'b1; v[B_RD] = 1'b1; end
         8:     begin v[B_SRCA] = 1'b1; v[4:3] = 2'b01; v[B_PWC] = 1'b1; v[6:5] = 2'b01; end
         9:     begin v[B_PW] = 1'b1; v[6:5] = 2'b10; end
         11:    v[B_RW] = 1'b1;
         default: ;
      endcase
      return v;
   endfunction

   function automatic logic [5:0] rand_op();
      logic [5:0] op;
      case ($urandom_range(0, 5))
         0:       op = OP_R;
         1:       op = OP_LW;
         2:       op = OP_SW;
         3:       op = OP_BEQ;
         4:       op = OP_J;
         default: op = OP_ADDI;
      endcase
      return op;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int W  = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 2 : 15;
      localparam int NR = (W == 15) ? 500 : (W == 2) ? 1000 : 2500;

      logic        rst;
      logic [5:0]  opc;
      logic [20:0] expv;
      logic [20:0] pin_m;
      logic [20:0] pin_v;
      logic        chk;
      logic        pin_en;
      logic        done;
      logic        ill;
      pin_t        pq[$];

      logic        pwc, pw, iord, mr, mw, m2r, irw, srca, rw, rd, illo;
      logic [1:0]  pcs, aop, srcb;
      logic [3:0]  st;

      multicycle_control #(.MEM_WAIT(W), .OPC_W(6)) u_dut (
         .clk(clk), .reset(rst), .opCode(opc),
         .PCWriteCond(pwc), .PCWrite(pw), .IorD(iord), .MemRead(mr),
         .MemWrite(mw), .MemtoReg(m2r), .IRWrite(irw), .ALUSrcA(srca),
         .RegWrite(rw), .RegDst(rd), .PCSource(pcs), .ALUOp(aop),
         .ALUSrcB(srcb), .illegal_op(illo), .state(st)
      );

      assign obs_a[g]    = {st, pwc, pw, iord, mr, mw, m2r, irw, srca, rw, rd, pcs, aop, srcb, illo};
      assign exp_a[g]    = expv;
      assign pin_m_a[g]  = pin_m;
      assign pin_v_a[g]  = pin_v;
      assign chk_a[g]    = chk;
      assign pin_en_a[g] = pin_en;
      assign done_a[g]   = done;

      // Literal expectation on the state field plus the masked strobes.
      task automatic pin(input int s, input logic [16:0] m, input logic [16:0] v);
         pin_t p;
         p.m = {4'hF, m};
         p.v = {4'(s), v};
         pq.push_back(p);
      endtask

      task automatic step(input logic [20:0] v);
         pin_t p;
         expv = v;
         chk  = 1'b1;
         if (pq.size() != 0) begin
            p      = pq.pop_front();
            pin_m  = p.m;
            pin_v  = p.v;
            pin_en = 1'b1;
         end else begin
            pin_en = 1'b0;
         end
         @(posedge clk);
         #1;
      endtask

      // One instruction as its sequence of phases, FETCH to FETCH.
      task automatic play(input logic [5:0] op);
         opc = op;
         for (int i = 0; i <= W; i++) step(vec(0, i == W, 1'b0, ill));
         step(vec(1, 1'b0, 1'b0, ill));
         case (op)
            OP_R:    begin step(vec(6, 1'b0, 1'b0, ill)); step(vec(7, 1'b0, 1'b0, ill)); end
            OP_LW:   begin
               step(vec(2, 1'b0, 1'b0, ill));
               for (int i = 0; i <= W; i++) step(vec(3, 1'b0, 1'b0, ill));
               step(vec(4, 1'b0, 1'b0, ill));
            end
            OP_SW:   begin
               step(vec(2, 1'b0, 1'b0, ill));
               for (int i = 0; i <= W; i++) step(vec(5, 1'b0, 1'b0, ill));
            end
            OP_BEQ:  step(vec(8, 1'b0, 1'b0, ill));
            OP_J:    step(vec(9, 1'b0, 1'b0, ill));
            OP_ADDI: begin step(vec(10, 1'b0, 1'b0, ill)); step(vec(11, 1'b0, 1'b0, ill)); end
            default: ill = 1'b1;
         endcase
      endtask

      initial begin
         rst    = 1'b1;
         opc    = OP_R;
         chk    = 1'b0;
         pin_en = 1'b0;
         pin_m  = '0;
         pin_v  = '0;
         done   = 1'b0;
         ill    = 1'b0;
         expv   = vec(0, W == 0, 1'b1, 1'b0);
         #1;
         chk = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         rst = 1'b0;

         if (g == 0) begin
            pin(0, M_RW | M_M2R, 17'd0); pin(1, M_RW | M_M2R, 17'd0);
            pin(2, M_RW | M_M2R, 17'd0); pin(3, M_RW | M_M2R, 17'd0);
            pin(4, M_RW | M_M2R, M_RW | M_M2R);
            play(OP_LW);
            pin(0, M_PWC | M_PCS, 17'd0); pin(1, M_PWC | M_PCS, 17'd0);
            pin(8, M_PWC | M_PCS, M_PWC | 17'h00020);
            play(OP_BEQ);
            pin(0, M_PW | M_PCS, M_PW); pin(1, M_PW | M_PCS, 17'd0);
            pin(9, M_PW | M_PCS, M_PW | 17'h00040);
            play(OP_J);
            pin(0, M_ILL, 17'd0); pin(1, M_ILL, 17'd0);
            play(OP_BAD);
            pin(0, M_ILL, M_ILL); pin(1, M_ILL, M_ILL); pin(6, M_ILL, M_ILL);
            pin(7, M_ILL | M_RW | M_RD, M_ILL | M_RW | M_RD);
            pin(0, M_ILL, M_ILL);
            play(OP_R);
         end

         if (g == 2) begin
            play(OP_BAD);
            pin(0, M_IRW | M_PW, 17'd0); pin(0, M_IRW | M_PW, 17'd0);
            pin(0, M_IRW | M_PW, M_IRW | M_PW);
            pin(1, M_MW, 17'd0); pin(2, M_MW, 17'd0);
            pin(5, M_MW, M_MW); pin(5, M_MW, M_MW); pin(5, M_MW, M_MW);
            play(OP_SW);
            // Store abandoned by an asynchronous reset in its 2nd write cycle.
            opc = OP_SW;
            for (int i = 0; i <= W; i++) step(vec(0, i == W, 1'b0, ill));
            step(vec(1, 1'b0, 1'b0, ill));
            step(vec(2, 1'b0, 1'b0, ill));
            pin(5, M_MW | M_ILL, M_MW | M_ILL);
            step(vec(5, 1'b0, 1'b0, ill));
            expv   = vec(5, 1'b0, 1'b0, ill);
            pin_en = 1'b0;
            #2;
            rst    = 1'b1;
            ill    = 1'b0;
            expv   = vec(0, W == 0, 1'b1, 1'b0);
            pin_m  = {4'hF, M_MW | M_ILL};
            pin_v  = '0;
            pin_en = 1'b1;
            @(posedge clk);
            #1;
            pin_en = 1'b0;
            rst    = 1'b0;
         end

         for (int n = 0; n < NR; n++) play(rand_op());

         chk    = 1'b0;
         pin_en = 1'b0;
         done   = 1'b1;
      end
   end

   // Single compare process for every instance.
   initial begin
      n_cmp = 0;
      n_bad = 0;
      forever begin
         @(negedge clk);
         for (int g = 0; g < NI; g++) begin
            if (chk_a[g]) begin
               n_cmp++;
               if (obs_a[g] !== exp_a[g]) begin
                  n_bad++;
                  $display("FAIL outputs inst%0d t=%0t: got %h, expected %h", g, $time, obs_a[g], exp_a[g]);
               end
            end
            if (pin_en_a[g]) begin
               n_cmp++;
               if ((obs_a[g] & pin_m_a[g]) !== pin_v_a[g]) begin
                  n_bad++;
                  $display("FAIL literal inst%0d t=%0t: got %h, expected %h (mask %h)",
                           g, $time, obs_a[g] & pin_m_a[g], pin_v_a[g], pin_m_a[g]);
               end
            end
         end
         if (fin_chk) begin
            n_cmp++;
            if (done_a !== {NI{1'b1}}) begin
               n_bad++;
               $display("FAIL completion: done flags %b, expected %b", done_a, {NI{1'b1}});
            end
         end
      end
   end

   initial begin
      fin_chk = 1'b0;
      for (int c = 0; c < 60000; c++) begin
         @(posedge clk);
         if (&done_a) break;
      end
      #1;
      fin_chk = 1'b1;
      @(posedge clk);
      #1;
      fin_chk = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
